// File: rtl/mitchell_antilog_if.sv
// Log-word input and product output handshake bundle for the Mitchell antilog stage.
// The master side produces log words and consumes products; the slave side is the antilog block.
interface mitchell_antilog_if #(
    parameter int FRAC_W = 7,
    parameter int K_W    = 4,
    parameter int OUT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [K_W-1:0]    in_k;
    logic [FRAC_W-1:0] in_frac;
    logic              in_zero;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_p;
    logic              out_sat;

    modport master (
        output in_valid, in_k, in_frac, in_zero, out_ready,
        input  in_ready, out_valid, out_p, out_sat
    );

    modport slave (
        input  in_valid, in_k, in_frac, in_zero, out_ready,
        output in_ready, out_valid, out_p, out_sat
    );
endinterface

// File: rtl/mitchell_antilog.sv
// Mitchell antilog back-end: rebuilds (1.f) * 2^k through a 2-stage elastic valid/ready pipeline.
// Define MITCHELL_ANTILOG_ROUND_EN to round right shifts to nearest (ties up) instead of truncating.
module mitchell_antilog #(
    parameter int FRAC_W = 7,
    parameter int K_W    = 4,
    parameter int OUT_W  = 16
) (
    input logic               clk,
    input logic               rst_n,
    mitchell_antilog_if.slave bus
);
    localparam int M_W    = FRAC_W + 1;
    localparam int SH_W   = M_W + (1 << K_W);
    // A word at least one bit wider than OUT_W keeps the overflow test valid for any parameter set.
    localparam int CALC_W = (SH_W > OUT_W) ? SH_W : OUT_W + 1;
    localparam logic [CALC_W-1:0] ONE = CALC_W'(1);

    logic              s1_valid_q, s1_valid_d;
    logic [M_W-1:0]    s1_m_q, s1_m_d;
    logic [K_W-1:0]    s1_k_q, s1_k_d;
    logic              s1_zero_q, s1_zero_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_p_q, out_p_d;
    logic              out_sat_q, out_sat_d;

    logic              s2_free;
    logic              s1_adv;
    logic              in_fire;
    logic [CALC_W-1:0] m_wide;
    logic [CALC_W-1:0] shifted;
    logic              over;

    // Readiness depends only on registered state and out_ready, never on in_valid.
    assign s2_free  = !out_valid_q || bus.out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_fire  = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !s1_valid_q || s2_free;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_sat   = out_sat_q;

    // NOTE: every signal gets a default at the top of a comb block so no path can infer a latch.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_m_d     = s1_m_q;
        s1_k_d     = s1_k_q;
        s1_zero_d  = s1_zero_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_m_d     = {1'b1, bus.in_frac};
            s1_k_d     = bus.in_k;
            s1_zero_d  = bus.in_zero;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        m_wide  = CALC_W'(s1_m_q);
        shifted = '0;
        if (int'(s1_k_q) >= FRAC_W) begin
            shifted = m_wide << (int'(s1_k_q) - FRAC_W);
        end else begin
`ifdef MITCHELL_ANTILOG_ROUND_EN
            // Half an output LSB is added first; a carry out of m is kept in the wider word.
            m_wide = m_wide + (ONE << (FRAC_W - int'(s1_k_q) - 1));
`endif
            shifted = m_wide >> (FRAC_W - int'(s1_k_q));
        end
        over = |(shifted >> OUT_W);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        out_sat_d   = out_sat_q;
        if (s1_adv) begin
            out_valid_d = 1'b1;
            if (s1_zero_q) begin
                out_p_d   = '0;
                out_sat_d = 1'b0;
            end else if (over) begin
                out_p_d   = '1;
                out_sat_d = 1'b1;
            end else begin
                out_p_d   = shifted[OUT_W-1:0];
                out_sat_d = 1'b0;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_m_q      <= '0;
            s1_k_q      <= '0;
            s1_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_m_q      <= s1_m_d;
            s1_k_q      <= s1_k_d;
            s1_zero_q   <= s1_zero_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_sat_q   <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_mitchell_antilog.sv
// Directed bench for mitchell_antilog: latency, values, streaming, backpressure and async reset.
// Expected values are hand-derived from (1.f) * 2^k with truncation or round-to-nearest.
module tb_mitchell_antilog;
    localparam int FRAC_W = 7;
    localparam int K_W    = 4;
    localparam int OUT_W  = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mitchell_antilog_if #(.FRAC_W(FRAC_W), .K_W(K_W), .OUT_W(OUT_W)) bus ();

    mitchell_antilog #(.FRAC_W(FRAC_W), .K_W(K_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic drive(input bit v, input int k, input int f, input bit z);
        bus.in_valid = v;
        bus.in_k     = K_W'(k);
        bus.in_frac  = FRAC_W'(f);
        bus.in_zero  = z;
    endtask

    // Called at a falling edge with the pipeline empty; checks 2-cycle latency and result.
    task automatic send_one(input string tag, input int k, input int f, input bit z,
                            input logic [15:0] exp_p, input bit exp_sat);
        bus.out_ready = 1'b1;
        drive(1'b1, k, f, z);
        #1 check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 0, 0, 1'b0);
        check({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_p"}, 32'(bus.out_p), 32'(exp_p));
        check({tag, "_sat"}, 32'(bus.out_sat), 32'(exp_sat));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 0, 0, 1'b0);

        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_p", 32'(bus.out_p), 32'd0);
        check("rst_out_sat", 32'(bus.out_sat), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        send_one("k3_f00", 3, 'h00, 1'b0, 16'd8, 1'b0);
        send_one("k7_f40", 7, 'h40, 1'b0, 16'd192, 1'b0);
        send_one("k7_f00", 7, 'h00, 1'b0, 16'd128, 1'b0);
        send_one("k15_f7f", 15, 'h7F, 1'b0, 16'hFF00, 1'b0);
`ifdef MITCHELL_ANTILOG_ROUND_EN
        send_one("k0_f7f", 0, 'h7F, 1'b0, 16'd2, 1'b0);
        send_one("k6_f3f", 6, 'h3F, 1'b0, 16'd96, 1'b0);
`else
        send_one("k0_f7f", 0, 'h7F, 1'b0, 16'd1, 1'b0);
        send_one("k6_f3f", 6, 'h3F, 1'b0, 16'd95, 1'b0);
`endif
        send_one("zero_k9", 9, 'h55, 1'b1, 16'd0, 1'b0);
        send_one("k12_f55", 12, 'h55, 1'b0, 16'h1AA0, 1'b0);

        // Back-to-back stream: word i presented at falling edge i, result at falling edge i+2.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive(1'b1, 8 + i, 0, 1'b0);
                #1 check($sformatf("stream_in_ready_%0d", i), 32'(bus.in_ready), 32'd1);
            end else begin
                drive(1'b0, 0, 0, 1'b0);
            end
            if (i >= 2) begin
                check($sformatf("stream_valid_%0d", i - 2), 32'(bus.out_valid), 32'd1);
                check($sformatf("stream_p_%0d", i - 2), 32'(bus.out_p), 32'd256 << (i - 2));
            end
            @(negedge clk);
        end
        check("stream_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: out_ready low for 5 cycles while words keep arriving.
        bus.out_ready = 1'b0;
        drive(1'b1, 8, 0, 1'b0);
        #1 check("stall_accept0", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 9, 0, 1'b0);
        #1 check("stall_accept1", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b1, 10, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("stall_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("stall_p_%0d", i), 32'(bus.out_p), 32'd256);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1 check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_p0", 32'(bus.out_p), 32'd256);
        @(negedge clk);
        check("release_p1", 32'(bus.out_p), 32'd512);
        drive(1'b1, 11, 0, 1'b0);
        #1 check("release_accept3", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 0, 0, 1'b0);
        check("release_valid2", 32'(bus.out_valid), 32'd1);
        check("release_p2", 32'(bus.out_p), 32'd1024);
        @(negedge clk);
        check("release_valid3", 32'(bus.out_valid), 32'd1);
        check("release_p3", 32'(bus.out_p), 32'd2048);
        @(negedge clk);
        check("release_drained", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset mid-stream, asserted and released between clock edges.
        drive(1'b1, 8, 0, 1'b0);
        @(negedge clk);
        drive(1'b1, 9, 0, 1'b0);
        @(negedge clk);
        drive(1'b0, 0, 0, 1'b0);
        check("pre_rst_p", 32'(bus.out_p), 32'd256);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_p", 32'(bus.out_p), 32'd0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(bus.out_valid), 32'd0);
        send_one("post_rst_k10", 10, 'h00, 1'b0, 16'd1024, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
